mem_burst_reader: RTL and testbench
===================================

// Module: mem_burst_reader
// PURPOSE
//  Downstream read sequencer for the 32-bit word memory. On a start command it walks
//  a contiguous address range, drives the memory's addr/read port, captures each word
//  into a small internal FIFO and presents it on a valid/ready stream with a last flag.
//  It decouples the memory (combinational read) from a stalling consumer (compute core).
// PARAMETERS
//  ADDR_W      8    memory address width
//  DATA_W      32   memory word width
//  FIFO_DEPTH  4    output FIFO entries (power of 2, >=2)
//  MAX_ADDR    128  highest legal memory index (memory holds words 0..MAX_ADDR)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle command pulse; sampled only in IDLE
//  base_addr  in   ADDR_W  first word index
//  length     in   ADDR_W  number of words to read (0 legal = empty burst)
//  busy       out  1       high from cycle after accepted start until done cycle inclusive
//  done       out  1       1-cycle pulse: burst finished and FIFO fully drained
//  err        out  1       1-cycle pulse with done when range illegal (no reads issued)
//  mem_addr   out  ADDR_W  to memory addr
//  mem_read   out  1       to memory read; memory datao valid same cycle
//  mem_data   in   DATA_W  from memory datao
//  out_data   out  DATA_W  FIFO head word
//  out_last   out  1       head word is final word of burst
//  out_valid  out  1       FIFO not empty
//  out_ready  in   1       consumer accepts head when out_valid&out_ready
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, counters 0; busy=done=err=mem_read=out_valid=out_last=0,
//   mem_addr=0, out_data=0. Reset mid-burst discards FIFO contents and in-flight count.
//  FSM: IDLE -> (start) CHECK-in-same-edge -> READ | FINISH; READ -> DRAIN -> FINISH -> IDLE.
//  IDLE: on start latch cur=base_addr, rem=length. end=base_addr+length-1 computed in
//   ADDR_W+1 bits. If length!=0 and end>MAX_ADDR: go FINISH with err flag set.
//   If length==0: go FINISH (no err). Else go READ.
//  READ: mem_read=1 and mem_addr=cur iff FIFO not full (count<FIFO_DEPTH) at cycle start;
//   a pop in the same cycle does NOT free a slot for that cycle's issue.
//   On issue: push {mem_data, rem==1} into FIFO on that edge, cur<=cur+1, rem<=rem-1;
//   when rem==1 at issue go DRAIN. mem_read=0 in all other states; mem_addr holds last value.
//  DRAIN: wait until FIFO empty (including final pop this cycle) -> FINISH.
//  FINISH: done=1 (err=1 if range flag set) for exactly one cycle, busy=1, -> IDLE.
//  Latency: start at cycle N -> first mem_read at N+1 -> out_valid at N+2. With out_ready
//   held 1, one word per cycle; done at N+length+2 (consumer pops last word at N+length+1).
//  Stream rules: out_data/out_last stable while out_valid&!out_ready; out_valid never drops
//   without a pop; simultaneous push and pop keeps count; FIFO pointers wrap mod FIFO_DEPTH.
//  start while busy is ignored (no queuing). Address never wraps: range check blocks it.
//  Boundary: base=MAX_ADDR,length=1 legal; base=MAX_ADDR,length=2 -> err.
// TESTING
//  1 Reset then idle: all outputs 0; start with length=0 -> done at N+1, err=0, no mem_read.
//  2 base=0x10,length=3, ready=1, mem=[0x10]=A,[0x11]=B,[0x12]=C -> out A,B,C on N+2..N+4,
//    out_last only with C, done at N+5, busy N+1..N+5.
//  3 base=0,length=10, ready=0 -> exactly 4 mem_reads then stall, out_data=word0 stable;
//    release ready -> all 10 words in order, no loss/dup, done once.
//  4 base=0x7F,length=3 (end 0x81>128) -> err&done pulse at N+1, zero mem_reads, out_valid=0.
//  5 ready toggling 1/0 every cycle over length=8 -> data order kept, count never >4.
//  6 rst asserted mid-burst (after 2 words) -> next cycle outputs at reset values; new
//    start base=5,length=1 -> single word [5] with out_last, done normally.

Source files
------------

// File: rtl/mem_burst_if.sv
// Command, memory-port and output-stream signals of the burst reader.
// The slave modport is the reader's view; the master modport is the controller and memory side.
interface mem_burst_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  start, base_addr, length, mem_data, out_ready,
    output busy, done, err, mem_addr, mem_read, out_data, out_last, out_valid
  );

  modport master (
    output start, base_addr, length, mem_data, out_ready,
    input  busy, done, err, mem_addr, mem_read, out_data, out_last, out_valid
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst read sequencer: walks a contiguous word range of a combinational-read memory
// and streams the words through a small FIFO to a valid/ready consumer.
module mem_burst_reader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_ADDR   = 128
) (
  input logic      clk,
  input logic      rst,
  mem_burst_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned END_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] addr_hold;
  logic              range_err;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              pop;
  logic [END_W-1:0]  end_addr;
  logic              start_bad;

  // Issue decision uses the occupancy at cycle start, so a same-cycle pop never frees a slot.
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign issue      = (state == READ) && !fifo_full;
  assign pop        = !fifo_empty && bus.out_ready;
  assign end_addr   = END_W'(bus.base_addr) + END_W'(bus.length) - END_W'(1);
  assign start_bad  = (bus.length != '0) && (end_addr > END_W'(MAX_ADDR));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start) state_nxt = (start_bad || bus.length == '0) ? FINISH : READ;
      READ:   if (issue && rem == ADDR_W'(1)) state_nxt = DRAIN;
      DRAIN:  if (fifo_empty || (count == CNT_W'(1) && pop)) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk, range flag and output FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= '0;
      rem       <= '0;
      addr_hold <= '0;
      range_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_last <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        cur       <= bus.base_addr;
        rem       <= bus.length;
        range_err <= start_bad;
      end
      if (issue) begin
        cur               <= cur + ADDR_W'(1);
        rem               <= rem - ADDR_W'(1);
        addr_hold         <= cur;
        fifo_data[wr_ptr] <= bus.mem_data;
        fifo_last[wr_ptr] <= (rem == ADDR_W'(1));
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // mem_addr holds the last issued address whenever no read is in progress.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == FINISH);
    bus.err       = (state == FINISH) && range_err;
    bus.mem_read  = issue;
    bus.mem_addr  = issue ? cur : addr_hold;
    bus.out_valid = !fifo_empty;
    bus.out_data  = fifo_data[rd_ptr];
    bus.out_last  = !fifo_empty && fifo_last[rd_ptr];
  end
endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: a queue model of issued-but-unconsumed words checked every
// cycle, plus directed bursts with hand-computed cycle-exact expectations.
module tb_mem_burst_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_burst_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_burst_reader #(.ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .MAX_ADDR(128)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hD000_0000 | ({24'h0, a} * 32'h0000_0101);
  endfunction

  assign bus.mem_data = mem_word(bus.mem_addr);

  int n_pass = 0;
  int n_total = 0;
  int reads = 0;
  int pops = 0;
  int dones = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_q [$];
  logic        exp_last_q [$];
  logic [7:0]  exp_addr = '0;
  int          exp_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: words enter on each read of the expected address and leave on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("data", bus.out_data, exp_q[0]);
        check("last", 32'(bus.out_last), 32'(exp_last_q[0]));
      end
      if (bus.mem_read) begin
        check("rd_allowed", 32'(exp_left > 0 && exp_q.size() < 4), 32'd1);
        check("rd_addr", 32'(bus.mem_addr), 32'(exp_addr));
      end
      if (bus.mem_read) reads++;
      if (bus.done) dones++;
      if (rst) begin
        exp_q.delete();
        exp_last_q.delete();
        exp_left = 0;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          pops++;
        end
        if (bus.mem_read) begin
          exp_q.push_back(mem_word(exp_addr));
          exp_last_q.push_back(exp_left == 1);
          exp_addr = exp_addr + 8'd1;
          exp_left = exp_left - 1;
        end
      end
    end
  end

  task automatic start_burst(input logic [7:0] b, input logic [7:0] l, input bit legal);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.length    = l;
    if (legal) begin
      exp_addr = b;
      exp_left = int'(l);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_err"},   32'(bus.err), 32'd0);
    check({tag, "_mread"}, 32'(bus.mem_read), 32'd0);
    check({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_last"},  32'(bus.out_last), 32'd0);
    check({tag, "_data"},  bus.out_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    int r0, p0, d0, n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Empty burst: done one cycle after start, no reads.
    r0 = reads;
    start_burst(8'h20, 8'd0, 1'b1);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_err", 32'(bus.err), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_done_off", 32'(bus.done), 32'd0);
    check("t1_busy_off", 32'(bus.busy), 32'd0);
    check("t1_reads", 32'(reads - r0), 32'd0);

    // Three words at 0x10 with a ready consumer.
    bus.out_ready = 1'b1;
    start_burst(8'h10, 8'd3, 1'b1);
    check("t2_n1_busy", 32'(bus.busy), 32'd1);
    check("t2_n1_mread", 32'(bus.mem_read), 32'd1);
    check("t2_n1_maddr", 32'(bus.mem_addr), 32'h10);
    check("t2_n1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t2_a", bus.out_data, 32'hD000_1010);
    check("t2_a_last", 32'(bus.out_last), 32'd0);
    tick();
    check("t2_b", bus.out_data, 32'hD000_1111);
    check("t2_b_last", 32'(bus.out_last), 32'd0);
    tick();
    check("t2_c", bus.out_data, 32'hD000_1212);
    check("t2_c_last", 32'(bus.out_last), 32'd1);
    check("t2_c_done", 32'(bus.done), 32'd0);
    tick();
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd1);
    check("t2_err", 32'(bus.err), 32'd0);
    tick();
    check("t2_busy_off", 32'(bus.busy), 32'd0);

    // Stalled consumer: exactly four reads fill the FIFO, head stays word 0.
    bus.out_ready = 1'b0;
    r0 = reads;
    start_burst(8'h00, 8'd10, 1'b1);
    repeat (8) tick();
    check("t3_reads", 32'(reads - r0), 32'd4);
    check("t3_head", bus.out_data, 32'hD000_0000);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    p0 = pops;
    d0 = dones;
    bus.out_ready = 1'b1;
    wait_done(40);
    check("t3_pops", 32'(pops - p0), 32'd10);
    tick();
    check("t3_dones", 32'(dones - d0), 32'd1);

    // Illegal range 0x7F..0x81 and the MAX_ADDR boundary.
    r0 = reads;
    start_burst(8'h7F, 8'd3, 1'b0);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t4_err_off", 32'(bus.err), 32'd0);
    check("t4_reads", 32'(reads - r0), 32'd0);
    start_burst(8'h80, 8'd2, 1'b0);
    check("t4b_err", 32'(bus.err), 32'd1);
    tick();
    start_burst(8'h80, 8'd1, 1'b1);
    check("t4c_err", 32'(bus.err), 32'd0);
    check("t4c_maddr", 32'(bus.mem_addr), 32'h80);
    tick();
    check("t4c_data", bus.out_data, 32'hD000_8080);
    check("t4c_last", 32'(bus.out_last), 32'd1);
    wait_done(10);
    check("t4c_err_done", 32'(bus.err), 32'd0);
    tick();

    // Ready toggling every cycle over eight words.
    p0 = pops;
    bus.out_ready = 1'b0;
    start_burst(8'h30, 8'd8, 1'b1);
    n = 0;
    while (!bus.done && n < 60) begin
      bus.out_ready = ~bus.out_ready;
      tick();
      n++;
    end
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_pops", 32'(pops - p0), 32'd8);
    tick();

    // Reset after two words, then a single-word burst at 5.
    bus.out_ready = 1'b1;
    p0 = pops;
    start_burst(8'h00, 8'd10, 1'b1);
    n = 0;
    while (pops - p0 < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t6_two_pops", 32'(pops - p0), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6");
    start_burst(8'h05, 8'd1, 1'b1);
    check("t6_mread", 32'(bus.mem_read), 32'd1);
    check("t6_maddr", 32'(bus.mem_addr), 32'h05);
    tick();
    check("t6_data", bus.out_data, 32'hD000_0505);
    check("t6_last", 32'(bus.out_last), 32'd1);
    tick();
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_err", 32'(bus.err), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
